// File: rtl/sonic_addr_xlate_pipe.sv
// Three-stage external-to-internal address translator for a paged circular buffer.
// Each page of PAGE_DATA payload words is preceded by HDR header words in the internal map.
module sonic_addr_xlate_pipe #(
    parameter int ADDR_W    = 15,
    parameter int PAGE_DATA = 496,
    parameter int HDR       = 16,
    parameter int NUM_PAGES = 64,
    parameter int TAG_W     = 4,
    localparam int PG_W     = (NUM_PAGES > 1) ? $clog2(NUM_PAGES) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [TAG_W-1:0]  in_tag,
    input  logic              wrap_en,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [PG_W-1:0]   out_page,
    output logic [TAG_W-1:0]  out_tag,
    output logic              out_wrapped,
    output logic              out_err,
    output logic [15:0]       err_cnt,
    input  logic              cnt_clr
);

    // One extra bit holds TOTAL itself and the header-adjusted sum without overflow.
    localparam int XW = ADDR_W + 1;
    localparam logic [XW-1:0] TOTAL = XW'(PAGE_DATA * NUM_PAGES);

    if ((longint'(PAGE_DATA + HDR) * longint'(NUM_PAGES) > (longint'(1) << ADDR_W))
        || (PAGE_DATA == 0) || (NUM_PAGES == 0)) begin : g_param_check
        $error("sonic_addr_xlate_pipe: page geometry does not fit ADDR_W");
    end

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic              vld_p0, vld_p1, vld_p2;
    logic              load_p0, load_p1, load_p2;
    logic [ADDR_W-1:0] addr_p0;
    logic [TAG_W-1:0]  tag_p0;
    logic              wrap_p0;

    assign load_p2   = ~vld_p2 | out_ready;
    assign load_p1   = ~vld_p1 | load_p2;
    assign load_p0   = ~vld_p0 | load_p1;
    assign in_ready  = load_p0;
    assign out_valid = vld_p2;

    // ---- stage 1: capture request ----
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_p0 <= 1'b0;
        end else if (load_p0) begin
            vld_p0 <= in_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (load_p0 && in_valid) begin
            addr_p0 <= in_addr;
            tag_p0  <= in_tag;
            wrap_p0 <= wrap_en;
        end
    end

    // ---- stage 2: fold into range and locate page ----
    logic [XW-1:0]        a_ext, a_sub, a_fold;
    logic                 fold_wrapped, fold_err;
    logic [NUM_PAGES-1:0] ge;
    logic [PG_W-1:0]      pg_s2;

    assign a_ext = XW'(addr_p0);
    assign a_sub = a_ext - TOTAL;

    always_comb begin
        a_fold       = a_ext;
        fold_wrapped = 1'b0;
        fold_err     = 1'b0;
        if (a_ext >= TOTAL) begin
            if (wrap_p0) begin
                a_fold = a_sub;
                if (a_sub >= TOTAL) begin
                    fold_err = 1'b1;
                end else begin
                    fold_wrapped = 1'b1;
                end
            end else begin
                fold_err = 1'b1;
            end
        end
    end

    assign ge[0] = 1'b1;
    for (genvar k = 1; k < NUM_PAGES; k++) begin : g_cmp
        assign ge[k] = (a_fold >= XW'(k * PAGE_DATA));
    end

    // Thresholds are monotonic, so the highest set comparator is the page.
    always_comb begin
        pg_s2 = '0;
        for (int k = 1; k < NUM_PAGES; k++) begin
            if (ge[k]) pg_s2 = PG_W'(k);
        end
    end

    logic [ADDR_W-1:0] a_p1;
    logic [PG_W-1:0]   pg_p1;
    logic [TAG_W-1:0]  tag_p1;
    logic              wrapped_p1, err_p1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_p1 <= 1'b0;
        end else if (load_p1) begin
            vld_p1 <= vld_p0;
        end
    end

    always_ff @(posedge clk) begin
        if (load_p1 && vld_p0) begin
            a_p1       <= a_fold[ADDR_W-1:0];
            pg_p1      <= pg_s2;
            tag_p1     <= tag_p0;
            wrapped_p1 <= fold_wrapped;
            err_p1     <= fold_err;
        end
    end

    // ---- stage 3: insert headers and present result ----
    logic [XW-1:0] xl;
    logic          unused_hi;

    assign xl        = XW'(a_p1) + XW'(HDR) * (XW'(pg_p1) + XW'(1));
    assign unused_hi = ^{xl[ADDR_W], a_fold[ADDR_W]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_p2      <= 1'b0;
            out_addr    <= '0;
            out_page    <= '0;
            out_tag     <= '0;
            out_wrapped <= 1'b0;
            out_err     <= 1'b0;
        end else if (load_p2) begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                out_addr    <= err_p1 ? '0 : xl[ADDR_W-1:0];
                out_page    <= err_p1 ? '0 : pg_p1;
                out_tag     <= tag_p1;
                out_wrapped <= wrapped_p1;
                out_err     <= err_p1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_cnt <= '0;
        end else if (cnt_clr) begin
            err_cnt <= '0;
        end else if (vld_p2 && out_ready && out_err) begin
            err_cnt <= sat_inc(err_cnt);
        end
    end

endmodule
